cdb_broadcaster: RTL and testbench

- Producer end of the common data bus (CDB) that the reservation stations snoop. Each station holds a waiting operand as a tag Q and captures the value when the bus carries Q with its valid strobe asserted.
- Functional units (add, mul/div, load) push completed results (tag + 32-bit value) into per-source 2-entry FIFOs.
- A round-robin arbiter picks one result per cycle and drives it onto the registered bus outputs.
- Tag 0 means "no producer pending" and is never broadcast.

---
 rtl/cdb_broadcaster_if.sv | 27 ++
 rtl/cdb_broadcaster.sv | 121 ++++++++++++
 tb/tb_cdb_broadcaster.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_broadcaster_if.sv
// Result-source and broadcast signal bundle for the CDB broadcaster.
// master is the broadcaster side; slave is the functional-unit / station side.
interface cdb_broadcaster_if #(
   parameter int NUM_SRC = 4,
   parameter int TAG_W   = 4,
   parameter int DATA_W  = 32
);
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC-1:0]        src_ready;
   logic [NUM_SRC*TAG_W-1:0]  src_tag;
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic                      cdb_valid;
   logic [TAG_W-1:0]          cdb_tag;
   logic [DATA_W-1:0]         cdb_data;
   logic                      tag_err;
   logic                      busy;

   modport master (
      input  src_valid, src_tag, src_data,
      output src_ready, cdb_valid, cdb_tag, cdb_data, tag_err, busy
   );

   modport slave (
      output src_valid, src_tag, src_data,
      input  src_ready, cdb_valid, cdb_tag, cdb_data, tag_err, busy
   );
endinterface

// File: rtl/cdb_broadcaster.sv
// Common data bus producer: per-source 2-entry result FIFOs drained one result
// per cycle by a round-robin arbiter onto a registered broadcast.
module cdb_broadcaster #(
   parameter int NUM_SRC    = 4,
   parameter int TAG_W      = 4,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input logic               clk,
   input logic               rst_n,
   input logic               flush,
   cdb_broadcaster_if.master bus
);
   localparam int         PTR_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int         SCAN_W   = PTR_W + 1;
   localparam int         ENT_W    = TAG_W + DATA_W;
   localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

   logic [ENT_W-1:0]   mem [NUM_SRC][2];
   logic [1:0]         count [NUM_SRC];
   logic [NUM_SRC-1:0] rd_ptr, wr_ptr;
   logic [NUM_SRC-1:0] non_empty, ready, push_ok, tag_zero, store, pop;
   logic [TAG_W-1:0]   in_tag [NUM_SRC];
   logic [DATA_W-1:0]  in_data [NUM_SRC];
   logic [PTR_W-1:0]   rr_ptr, winner, rr_next;
   logic [SCAN_W-1:0]  scan;
   logic               grant;
   logic [ENT_W-1:0]   head;
   logic               cdb_valid_q, tag_err_q;
   logic [TAG_W-1:0]   cdb_tag_q;
   logic [DATA_W-1:0]  cdb_data_q;

   // Ready depends only on the registered count, so a full FIFO refuses a push
   // even in the cycle it is popped; tag-0 pushes handshake but are not stored.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         in_tag[i]    = bus.src_tag[i*TAG_W +: TAG_W];
         in_data[i]   = bus.src_data[i*DATA_W +: DATA_W];
         non_empty[i] = (count[i] != 2'd0);
         ready[i]     = (count[i] < FULL_CNT);
         push_ok[i]   = bus.src_valid[i] & ready[i];
         tag_zero[i]  = (in_tag[i] == '0);
         store[i]     = push_ok[i] & ~tag_zero[i];
      end
   end

   always_comb begin
      grant   = 1'b0;
      winner  = '0;
      rr_next = rr_ptr;
      scan    = '0;
      pop     = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         scan = {1'b0, rr_ptr} + SCAN_W'(k);
         if (scan >= SCAN_W'(NUM_SRC)) begin
            scan = scan - SCAN_W'(NUM_SRC);
         end
         if (!grant && non_empty[scan[PTR_W-1:0]]) begin
            grant  = 1'b1;
            winner = scan[PTR_W-1:0];
         end
      end
      if (grant) begin
         rr_next     = (winner == PTR_W'(NUM_SRC - 1)) ? '0 : winner + 1'b1;
         pop[winner] = 1'b1;
      end
      head = mem[winner][rd_ptr[winner]];
   end

   // Flush outranks both push and grant; the bus tag/data hold when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            count[i] <= '0;
         end
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         rr_ptr      <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
         tag_err_q   <= 1'b0;
      end else if (flush) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            count[i] <= '0;
         end
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         rr_ptr      <= '0;
         cdb_valid_q <= 1'b0;
         tag_err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            count[i] <= count[i] + {1'b0, store[i]} - {1'b0, pop[i]};
         end
         rd_ptr      <= rd_ptr ^ pop;
         wr_ptr      <= wr_ptr ^ store;
         tag_err_q   <= |(push_ok & tag_zero);
         cdb_valid_q <= grant;
         if (grant) begin
            rr_ptr                   <= rr_next;
            {cdb_tag_q, cdb_data_q}  <= head;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (store[i]) begin
            mem[i][wr_ptr[i]] <= {in_tag[i], in_data[i]};
         end
      end
   end

   assign bus.src_ready = ready;
   assign bus.cdb_valid = cdb_valid_q;
   assign bus.cdb_tag   = cdb_tag_q;
   assign bus.cdb_data  = cdb_data_q;
   assign bus.tag_err   = tag_err_q;
   assign bus.busy      = |non_empty;
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench for cdb_broadcaster: directed pushes queue their expected
// broadcasts, and a negedge monitor pops and compares every valid bus cycle.
module tb_cdb_broadcaster;
   localparam int NUM_SRC = 4;
   localparam int TAG_W   = 4;
   localparam int DATA_W  = 32;
   localparam int ENT_W   = TAG_W + DATA_W;

   logic clk;
   logic rst_n;
   logic flush;
   int   tests = 0;
   int   fails = 0;

   logic [ENT_W-1:0] expq [$];
   logic [ENT_W-1:0] mon_exp;
   logic [3:0]       ord2 [4] = '{4'd3, 4'd4, 4'd1, 4'd2};

   cdb_broadcaster_if #(.NUM_SRC(NUM_SRC), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

   cdb_broadcaster #(
      .NUM_SRC(NUM_SRC), .TAG_W(TAG_W), .DATA_W(DATA_W), .FIFO_DEPTH(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: actual %h, required %h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setSrc(input int i, input logic [3:0] tag, input logic [31:0] data);
      bus.src_tag[i*TAG_W +: TAG_W]    = tag;
      bus.src_data[i*DATA_W +: DATA_W] = data;
   endtask

   task automatic expectBcast(input logic [3:0] tag, input logic [31:0] data);
      expq.push_back({tag, data});
   endtask

   task automatic applyStimulus(input logic [3:0] valid, input logic fl);
      bus.src_valid = valid;
      flush         = fl;
      tick();
      bus.src_valid = '0;
      flush         = 1'b0;
   endtask

   // Monitor: every valid broadcast must match the next expected entry.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.cdb_valid) begin
            checkOutput("bcast_tag_nonzero", 64'(bus.cdb_tag == '0), 64'd0);
            if (expq.size() == 0) begin
               checkOutput("bcast_unexpected", 64'({bus.cdb_tag, bus.cdb_data}), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               mon_exp = expq.pop_front();
               checkOutput("bcast", 64'({bus.cdb_tag, bus.cdb_data}), 64'(mon_exp));
            end
         end
      end
   end

   initial begin
      int a_sent, b_sent, cyc, a_done_cyc;
      logic [3:0] rdy;

      rst_n         = 1'b0;
      flush         = 1'b0;
      bus.src_valid = '0;
      bus.src_tag   = '0;
      bus.src_data  = '0;

      // Reset values
      #2;
      checkOutput("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
      checkOutput("rst_cdb_tag", 64'(bus.cdb_tag), 64'd0);
      checkOutput("rst_cdb_data", 64'(bus.cdb_data), 64'd0);
      checkOutput("rst_tag_err", 64'(bus.tag_err), 64'd0);
      checkOutput("rst_busy", 64'(bus.busy), 64'd0);
      #10;
      rst_n = 1'b1;
      #1;
      checkOutput("rst_src_ready", 64'(bus.src_ready), 64'hF);
      tick();

      // Single push: two-cycle latency, one-cycle pulse, tag/data hold after
      setSrc(2, 4'd5, 32'h0000_00AB);
      expectBcast(4'd5, 32'h0000_00AB);
      applyStimulus(4'b0100, 1'b0);
      checkOutput("lat_not_early", 64'(bus.cdb_valid), 64'd0);
      checkOutput("lat_busy_set", 64'(bus.busy), 64'd1);
      tick();
      checkOutput("lat_valid", 64'(bus.cdb_valid), 64'd1);
      checkOutput("lat_tag", 64'(bus.cdb_tag), 64'd5);
      checkOutput("lat_data", 64'(bus.cdb_data), 64'hAB);
      checkOutput("lat_busy_clear", 64'(bus.busy), 64'd0);
      tick();
      checkOutput("pulse_one_cycle", 64'(bus.cdb_valid), 64'd0);
      checkOutput("idle_tag_hold", 64'(bus.cdb_tag), 64'd5);

      // Contention with rr_ptr=0 (flush forces it)
      applyStimulus(4'b0000, 1'b1);
      for (int i = 0; i < 4; i++) begin
         setSrc(i, 4'(i + 1), 32'h100 + 32'(i));
         expectBcast(4'(i + 1), 32'h100 + 32'(i));
      end
      applyStimulus(4'hF, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
         checkOutput("cont0_valid", 64'(bus.cdb_valid), 64'd1);
         checkOutput("cont0_tag", 64'(bus.cdb_tag), 64'(k + 1));
         tick();
      end
      checkOutput("cont0_idle", 64'(bus.cdb_valid), 64'd0);

      // Contention with rr_ptr=2: a lone grant to source 1 moves the pointer
      setSrc(1, 4'd6, 32'h600);
      expectBcast(4'd6, 32'h600);
      applyStimulus(4'b0010, 1'b0);
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         setSrc(i, 4'(i + 1), 32'h200 + 32'(i));
      end
      for (int k = 0; k < 4; k++) begin
         expectBcast(ord2[k], 32'h200 + 32'(ord2[k]) - 32'd1);
      end
      applyStimulus(4'hF, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
         checkOutput("cont2_tag", 64'(bus.cdb_tag), 64'(ord2[k]));
         tick();
      end

      // Backpressure: flush (rr=0), lone grant to source 0 (rr=1), then
      // sources 0 and 1 push three each; source 0 fills after two accepts.
      applyStimulus(4'b0000, 1'b1);
      setSrc(0, 4'd7, 32'h700);
      expectBcast(4'd7, 32'h700);
      applyStimulus(4'b0001, 1'b0);
      tick();
      tick();
      expectBcast(4'd11, 32'hB000_0000);
      expectBcast(4'd8,  32'hA000_0000);
      expectBcast(4'd12, 32'hB000_0001);
      expectBcast(4'd9,  32'hA000_0001);
      expectBcast(4'd13, 32'hB000_0002);
      expectBcast(4'd10, 32'hA000_0002);
      a_sent     = 0;
      b_sent     = 0;
      cyc        = 0;
      a_done_cyc = -1;
      while ((a_sent < 3 || b_sent < 3) && cyc < 20) begin
         bus.src_valid = {2'b00, b_sent < 3, a_sent < 3};
         setSrc(0, 4'(8 + a_sent), 32'hA000_0000 + 32'(a_sent));
         setSrc(1, 4'(11 + b_sent), 32'hB000_0000 + 32'(b_sent));
         rdy = bus.src_ready;
         tick();
         if (bus.src_valid[0] && rdy[0]) a_sent++;
         if (bus.src_valid[1] && rdy[1]) b_sent++;
         if (a_sent == 3 && a_done_cyc < 0) a_done_cyc = cyc;
         if (cyc == 1) checkOutput("bp_ready0_low", 64'(bus.src_ready[0]), 64'd0);
         cyc++;
      end
      bus.src_valid = '0;
      checkOutput("bp_a_accepted", 64'(a_sent), 64'd3);
      checkOutput("bp_b_accepted", 64'(b_sent), 64'd3);
      checkOutput("bp_a_accept_cycle", 64'(a_done_cyc), 64'd3);
      for (int k = 0; k < 5; k++) tick();

      // Tag 0 pushes: accepted, single error pulse, nothing stored
      setSrc(3, 4'd0, 32'hDEAD_BEEF);
      checkOutput("tz_ready", 64'(bus.src_ready[3]), 64'd1);
      applyStimulus(4'b1000, 1'b0);
      checkOutput("tz_err_pulse", 64'(bus.tag_err), 64'd1);
      checkOutput("tz_busy", 64'(bus.busy), 64'd0);
      tick();
      checkOutput("tz_err_clear", 64'(bus.tag_err), 64'd0);
      checkOutput("tz_no_bcast", 64'(bus.cdb_valid), 64'd0);
      setSrc(1, 4'd0, 32'h1111);
      setSrc(3, 4'd0, 32'h3333);
      applyStimulus(4'b1010, 1'b0);
      checkOutput("tz2_err_pulse", 64'(bus.tag_err), 64'd1);
      tick();
      checkOutput("tz2_err_single", 64'(bus.tag_err), 64'd0);

      // Flush with FIFOs loaded and a concurrent push
      applyStimulus(4'b0000, 1'b1);
      for (int i = 0; i < 4; i++) setSrc(i, 4'(i + 1), 32'h500 + 32'(i));
      applyStimulus(4'hF, 1'b0);
      for (int i = 0; i < 4; i++) setSrc(i, 4'(i + 5), 32'h510 + 32'(i));
      expectBcast(4'd1, 32'h500);
      applyStimulus(4'hF, 1'b0);
      checkOutput("fl_pre_tag", 64'(bus.cdb_tag), 64'd1);
      setSrc(0, 4'd9, 32'h999);
      applyStimulus(4'b0001, 1'b1);
      checkOutput("fl_valid", 64'(bus.cdb_valid), 64'd0);
      checkOutput("fl_busy", 64'(bus.busy), 64'd0);
      checkOutput("fl_ready", 64'(bus.src_ready), 64'hF);
      for (int k = 0; k < 6; k++) begin
         tick();
         checkOutput("fl_idle", 64'(bus.cdb_valid), 64'd0);
      end

      // Asynchronous reset mid-burst
      for (int i = 0; i < 4; i++) setSrc(i, 4'(i + 1), 32'h700 + 32'(i));
      expectBcast(4'd1, 32'h700);
      applyStimulus(4'hF, 1'b0);
      tick();
      tick();
      checkOutput("ar_pre_tag", 64'(bus.cdb_tag), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("ar_valid_drop", 64'(bus.cdb_valid), 64'd0);
      checkOutput("ar_tag_clear", 64'(bus.cdb_tag), 64'd0);
      checkOutput("ar_busy", 64'(bus.busy), 64'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
      checkOutput("ar_ready", 64'(bus.src_ready), 64'hF);
      for (int k = 0; k < 6; k++) begin
         tick();
         checkOutput("ar_idle", 64'(bus.cdb_valid), 64'd0);
      end

      checkOutput("queue_drained", 64'(expq.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
